muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the pipeline's HI/LO instructions (MULT, MULTU, DIV, DIVU). It owns an external ALU instance and drives its A/B/ALUFun/Sign inputs each cycle, reading back Z. Add, subtract and NOR steps run through that ALU; the sequencer holds only registers, muxes and carry/borrow logic. The block runs at a fixed latency and raises busy so the pipeline stalls MFHI/MFLO.

---
 rtl/muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer. It borrows an external ALU for every add/sub/nor step.
// Fixed latency: a start accepted in cycle 0 produces done in cycle 37.
module muldiv_seq #(
  parameter logic [5:0] FUN_ADD = 6'b000000,
  parameter logic [5:0] FUN_SUB = 6'b000001,
  parameter logic [5:0] FUN_NOR = 6'b010001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_z
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        lo_nz_q, lo_nz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic [31:0] t;
  logic        carry, borrow, ok, sgn;

  assign t        = {hi_q[30:0], lo_q[31]};
  assign carry    = (hi_q[31] & b_q[31]) | ((hi_q[31] | b_q[31]) & ~alu_z[31]);
  assign borrow   = (~t[31] & b_q[31]) | ((~t[31] | b_q[31]) & alu_z[31]);
  assign ok       = hi_q[31] | ~borrow;
  assign sgn      = ~op[0];
  assign alu_sign = 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // ALU operands must be combinational: alu_z is consumed in the same cycle.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = FUN_ADD;
    case (state_q)
      S_NEG_A:  begin alu_fun = FUN_SUB; alu_b = a_q; end
      S_NEG_B:  begin alu_fun = FUN_SUB; alu_b = b_q; end
      S_ITER:   begin
        alu_b = b_q;
        if (is_div_q) begin alu_fun = FUN_SUB; alu_a = t; end
        else          begin alu_fun = FUN_ADD; alu_a = hi_q; end
      end
      S_FIX_LO: begin alu_fun = FUN_SUB; alu_b = lo_q; end
      S_FIX_HI: begin
        // A nonzero negated low word means no carry into hi, so hi is just inverted.
        if (!is_div_q && lo_nz_q) begin alu_fun = FUN_NOR; alu_a = hi_q; end
        else                      begin alu_fun = FUN_SUB; alu_b = hi_q; end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    lo_nz_d  = lo_nz_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_NEG_A;
        is_div_d = op[1];
        neg_a_d  = sgn & rs[31];
        neg_b_d  = sgn & rt[31];
        lo_nz_d  = 1'b0;
        cnt_d    = 5'd31;
        a_d      = rs;
        b_d      = rt;
      end
      S_NEG_A: begin
        if (neg_a_q) a_d = alu_z;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        if (neg_b_q) b_d = alu_z;
        hi_d    = '0;
        lo_d    = a_q;
        cnt_d   = 5'd31;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (is_div_q) begin
          hi_d = ok ? alu_z : t;
          lo_d = {lo_q[30:0], ok};
        end else if (lo_q[0]) begin
          hi_d = {carry, alu_z[31:1]};
          lo_d = {alu_z[0], lo_q[31:1]};
        end else begin
          hi_d = {1'b0, hi_q[31:1]};
          lo_d = {hi_q[0], lo_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX_LO;
      end
      S_FIX_LO: begin
        if (neg_a_q ^ neg_b_q) begin
          lo_d = alu_z;
          if (!is_div_q) lo_nz_d = |lo_q;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        // Remainder follows the dividend's sign; product high word follows the result sign.
        if (is_div_q ? neg_a_q : (neg_a_q ^ neg_b_q)) hi_d = alu_z;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      lo_nz_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      lo_nz_q  <= lo_nz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU closing the loop.
// Cycle n begins just after the n-th sampled posedge; a start driven in cycle 0 should yield done in cycle 37.
module tb_muldiv_seq;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_NOR = 6'b010001;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, alu_sign;
  logic [31:0] hi, lo, alu_a, alu_b, alu_z;
  logic [5:0]  alu_fun;

  int passed = 0;
  int total  = 0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_z = '0;
    case (alu_fun)
      FUN_ADD: alu_z = alu_a + alu_b;
      FUN_SUB: alu_z = alu_a - alu_b;
      FUN_NOR: alu_z = ~(alu_a | alu_b);
      default: alu_z = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one op in the current (idle) cycle, returns in cycle 38 so a back-to-back start is possible.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                     input string tag, input bit stray);
    bit bad;
    bad = 1'b0;
    op = o; rs = a; rt = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy@1"}, {31'd0, busy}, 32'd1);
    for (int c = 1; c < 37; c++) begin
      if (done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      if (c == 10) chk({tag, " alu_fun@10"}, {26'd0, alu_fun}, {26'd0, o[1] ? FUN_SUB : FUN_ADD});
      if (stray && (c == 5 || c == 20)) begin
        start = 1'b1; op = ~o; rs = ~a; rt = 32'd3;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk({tag, " busy/done 1..36"}, {31'd0, bad}, 32'd0);
    chk({tag, " done@37"}, {31'd0, done}, 32'd1);
    chk({tag, " busy@37"}, {31'd0, busy}, 32'd1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    tick();
    chk({tag, " done@38"}, {31'd0, done}, 32'd0);
    chk({tag, " busy@38"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit bad;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("idle alu_a", alu_a, 32'd0);
    chk("idle alu_fun", {26'd0, alu_fun}, {26'd0, FUN_ADD});
    chk("alu_sign", {31'd0, alu_sign}, 32'd0);

    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "MULTU max", 1'b0);
    run(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "MULT -3*5", 1'b0);
    run(2'b00, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, "MULT min*1", 1'b0);
    run(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "MULT min*min", 1'b0);
    run(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       "DIVU 100/7", 1'b0);
    run(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2", 1'b0);
    run(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "DIV 7/-2", 1'b0);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "DIV min/-1", 1'b0);
    run(2'b11, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, "DIVU x/0", 1'b0);

    // Stray starts mid-run are ignored; the follow-on op starts in cycle 38 and finishes in cycle 75.
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "stray MULTU", 1'b1);
    run(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       "b2b DIVU", 1'b0);

    // Reset asserted in cycle 15 of a MULTU aborts it.
    op = 2'b01; rs = 32'hDEADBEEF; rt = 32'h12345678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("abort quiet", {31'd0, bad}, 32'd0);
    run(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, "DIVU 9/3", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
